// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the RX framing state type.
// The CRC constants assume the MSB-first register form used by crc32_d8.
package eth_pkg;
  localparam logic [3:0]  ETH_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  ETH_SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE    = 32'hC704DD7B;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;
endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 step. Data bits are consumed LSB first (wire order),
// and the register shifts MSB-first, so a good frame leaves CRC32_RESIDUE behind.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_out = crc_step(crc_in, data);

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: nibble-to-byte assembly, preamble/SFD strip, FCS/length/rx_er checks.
// Bytes leave one behind the wire so the final byte can carry m_last and the frame verdict.
module mii_rx_deframer
  import eth_pkg::*;
#(
  parameter int MIN_PREAMBLE = 4,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [3:0]  mii_rxd,
  input  logic        mii_rx_dv,
  input  logic        mii_rx_er,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_first,
  output logic        m_last,
  output logic        m_err,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad,
  output rx_state_e   dbg_state
);

  // Output stream: m_valid is a one-cycle strobe per byte with no ready; m_first/m_last
  // qualify it, and m_err is meaningful only alongside m_last.

  rx_state_e   state, state_next;
  logic [3:0]  pre_cnt;
  logic        nib_phase;
  logic [3:0]  lo_nib;
  logic [7:0]  hold_byte;
  logic        hold_valid;
  logic        hold_first;
  logic [10:0] len_cnt;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic        er_seen;
  logic [7:0]  new_byte;
  logic        byte_done;
  logic        frame_end;
  logic        overflow;
  logic        start_data;
  logic        end_bad;

  assign new_byte  = {mii_rxd, lo_nib};
  assign dbg_state = state;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (new_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    byte_done  = (state == ST_DATA) && mii_rx_dv && nib_phase;
    frame_end  = (state == ST_DATA) && !mii_rx_dv;
    overflow   = byte_done && (len_cnt == 11'(MAX_FRAME));
    start_data = (state == ST_PREAMBLE) && mii_rx_dv && !mii_rx_er &&
                 (mii_rxd == ETH_SFD_NIB) && (pre_cnt >= 4'(MIN_PREAMBLE));
    end_bad    = (crc != CRC32_RESIDUE) || er_seen || nib_phase ||
                 (len_cnt < 11'(MIN_FRAME));
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mii_rx_dv) state_next = (mii_rxd == ETH_PREAMBLE_NIB) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!mii_rx_dv)                        state_next = ST_IDLE;
        else if (mii_rx_er)                    state_next = ST_DROP;
        else if (mii_rxd == ETH_PREAMBLE_NIB)  state_next = ST_PREAMBLE;
        else if (start_data)                   state_next = ST_DATA;
        else                                   state_next = ST_DROP;
      end
      ST_DATA: begin
        if (!mii_rx_dv)    state_next = ST_IDLE;
        else if (overflow) state_next = ST_DROP;
      end
      default: begin
        if (!mii_rx_dv) state_next = ST_IDLE;
      end
    endcase
  end

  // Reset lands in DROP so a frame already on the wire is never picked up mid-way.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_DROP;
    else        state <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_first    <= 1'b0;
      m_last     <= 1'b0;
      m_err      <= 1'b0;
      frames_ok  <= '0;
      frames_bad <= '0;
      pre_cnt    <= '0;
      nib_phase  <= 1'b0;
      lo_nib     <= '0;
      hold_byte  <= '0;
      hold_valid <= 1'b0;
      hold_first <= 1'b0;
      len_cnt    <= '0;
      crc        <= CRC32_INIT;
      er_seen    <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
      m_err   <= 1'b0;

      if (state == ST_IDLE && mii_rx_dv && mii_rxd == ETH_PREAMBLE_NIB)
        pre_cnt <= 4'd1;
      else if (state == ST_PREAMBLE && mii_rx_dv && !mii_rx_er &&
               mii_rxd == ETH_PREAMBLE_NIB && pre_cnt != 4'hF)
        pre_cnt <= pre_cnt + 4'd1;

      if (start_data) begin
        nib_phase  <= 1'b0;
        hold_valid <= 1'b0;
        len_cnt    <= '0;
        crc        <= CRC32_INIT;
        er_seen    <= 1'b0;
      end

      if (state == ST_DATA && mii_rx_dv) begin
        if (mii_rx_er) er_seen <= 1'b1;
        nib_phase <= ~nib_phase;
        if (!nib_phase) lo_nib <= mii_rxd;
      end

      if (byte_done) begin
        crc        <= crc_next;
        if (len_cnt != 11'h7FF) len_cnt <= len_cnt + 11'd1;
        hold_byte  <= new_byte;
        hold_valid <= 1'b1;
        hold_first <= ~hold_valid;
        if (hold_valid) begin
          m_valid <= 1'b1;
          m_data  <= hold_byte;
          m_first <= hold_first;
        end
        // Oversize: the held byte closes the frame as bad; the rest is dropped.
        if (overflow) begin
          m_last     <= 1'b1;
          m_err      <= 1'b1;
          frames_bad <= frames_bad + 16'd1;
        end
      end

      if (frame_end) begin
        if (hold_valid) begin
          m_valid <= 1'b1;
          m_data  <= hold_byte;
          m_first <= hold_first;
          m_last  <= 1'b1;
          m_err   <= end_bad;
          if (end_bad) frames_bad <= frames_bad + 16'd1;
          else         frames_ok  <= frames_ok + 16'd1;
        end else begin
          frames_bad <= frames_bad + 16'd1;
        end
      end
    end
  end

endmodule
